// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for a single memory port.
//   Parameter: TIMEOUT_CYCLES (1..255) owned cycles without done before forced release.
//   Macro: ARB_TIMEOUT_EN enables the ownership watchdog; without it timeout is tied 0.
//   Inputs : clk, rst_n (async active-low), req0/req1, addr0/addr1, wdata0/wdata1, done.
//   Outputs: gnt0/gnt1, mem_req, sel (registered); mem_addr/mem_wdata (comb mux by sel);
//            timeout (one-cycle pulse on watchdog release).
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        done,
  output logic        gnt0,
  output logic        gnt1,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        sel,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  state_e state_q, state_d;
  logic   sel_q, sel_d, last_q, last_d;
  logic   gnt0_q, gnt1_q, mem_req_q, timeout_q;
  logic   owned, pick1, grant, wd_fire;
  // last_q=1 means port 1 was served last, so port 0 wins a tie
  always_comb begin
    owned   = state_q != IDLE;
    pick1   = req1 & (~req0 | ~last_q);
    grant   = ~owned & (req0 | req1);
    state_d = owned ? ((done | wd_fire) ? IDLE : state_q) : (pick1 ? OWN1 : (req0 ? OWN0 : IDLE));
    sel_d   = grant ? pick1 : sel_q;
    last_d  = grant ? pick1 : last_q;
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  // Counter sits at 0 in IDLE, so it is already clear on entry to ownership
  always_comb begin
    cnt_d   = owned ? cnt_q + 8'd1 : 8'd0;
    wd_fire = owned & ~done & (cnt_d == 8'(TIMEOUT_CYCLES));
  end
`else
  assign wd_fire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      mem_req_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt0_q    <= state_d == OWN0;
      gnt1_q    <= state_d == OWN1;
      mem_req_q <= state_d != IDLE;
      timeout_q <= wd_fire;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign mem_req   = mem_req_q;
  assign sel       = sel_q;
  assign timeout   = timeout_q;
  assign mem_addr  = sel_q ? addr1 : addr0;
  assign mem_wdata = sel_q ? wdata1 : wdata0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: model-checked directed bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, done = 0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic gnt0, gnt1, mem_req, sel, timeout;
  logic [31:0] mem_addr, mem_wdata;
  int checks = 0, errors = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .done(done),
    .gnt0(gnt0), .gnt1(gnt1), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sel(sel), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (-1 none), how long, who was served last.
  int m_own = -1, m_age = 0;
  bit m_last = 1, m_sel = 0, m_to = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_age = 0; m_last = 1; m_sel = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_own < 0) begin
        if (req0 && req1) m_own = m_last ? 0 : 1;
        else if (req0) m_own = 0;
        else if (req1) m_own = 1;
        if (m_own >= 0) begin
          m_sel = (m_own == 1); m_last = (m_own == 1); m_age = 0;
        end
      end else if (done) begin
        m_own = -1;
      end else begin
        m_age++;
`ifdef ARB_TIMEOUT_EN
        if (m_age == T) begin m_own = -1; m_to = 1; end
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt0", 32'(gnt0), 32'(m_own == 0));
    chk("gnt1", 32'(gnt1), 32'(m_own == 1));
    chk("mem_req", 32'(mem_req), 32'(m_own >= 0));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("mem_addr", mem_addr, m_sel ? addr1 : addr0);
    chk("mem_wdata", mem_wdata, m_sel ? wdata1 : wdata0);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic do_reset();
    rst_n = 0; tick(1); rst_n = 1;
  endtask

  bit order [4];

  initial begin
    #1;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_timeout", 32'(timeout), 0);
    tick(2); rst_n = 1;
    // single request on port 0
    addr0 = 32'h0000_1000; wdata0 = 32'h0000_00AA; req0 = 1;
    tick(1);
    chk("t26_gnt0", 32'(gnt0), 1);
    chk("t26_mem_req", 32'(mem_req), 1);
    chk("t26_sel", 32'(sel), 0);
    chk("t26_mem_addr", mem_addr, 32'h0000_1000);
    done = 1; tick(1); done = 0; req0 = 0;
    chk("t26_release", 32'(mem_req), 0);
    tick(1);
    // both requesting from reset: alternate 0,1,0,1 with IDLE gaps
    do_reset();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (!(gnt0 | gnt1) && w < 5) begin tick(1); w++; end
      if (w == 5) chk("t27_grant_wait", 32'(gnt0 | gnt1), 1);
      order[k] = gnt1;
      tick(1); done = 1; tick(1); done = 0;
      chk("t27_idle_gap", 32'(mem_req), 0);
    end
    req0 = 0; req1 = 0;
    chk("t27_order0", 32'(order[0]), 0);
    chk("t27_order1", 32'(order[1]), 1);
    chk("t27_order2", 32'(order[2]), 0);
    chk("t27_order3", 32'(order[3]), 1);
    tick(1);
    // port 1 release keeps sel and mux stable
    addr1 = 32'hDEAD_BEEF; wdata1 = 32'h1234_5678; req1 = 1;
    tick(1);
    chk("t28_gnt1", 32'(gnt1), 1);
    chk("t28_sel", 32'(sel), 1);
    tick(1); done = 1; req1 = 0; tick(1); done = 0;
    chk("t28_idle", 32'(mem_req), 0);
    chk("t28_sel_hold", 32'(sel), 1);
    chk("t28_addr_hold", mem_addr, 32'hDEAD_BEEF);
    tick(2);
    chk("t28_addr_hold2", mem_addr, 32'hDEAD_BEEF);
    chk("t28_wdata_hold", mem_wdata, 32'h1234_5678);
    // watchdog
    req1 = 1; tick(1); req1 = 0;
    chk("t29_gnt1", 32'(gnt1), 1);
`ifdef ARB_TIMEOUT_EN
    tick(3);
    chk("t29_still_owned", 32'(gnt1), 1);
    chk("t29_no_pulse_yet", 32'(timeout), 0);
    tick(1);
    chk("t29_released", 32'(gnt1), 0);
    chk("t29_pulse", 32'(timeout), 1);
    tick(1);
    chk("t29_pulse_end", 32'(timeout), 0);
    req1 = 1; tick(1); req1 = 0;
    tick(3); done = 1; tick(1); done = 0;
    chk("t29_done_release", 32'(gnt1), 0);
    chk("t29_done_no_pulse", 32'(timeout), 0);
`else
    tick(10);
    chk("t29_no_watchdog", 32'(gnt1), 1);
    chk("t29_timeout_tied", 32'(timeout), 0);
    done = 1; tick(1); done = 0;
    chk("t29_done_release", 32'(gnt1), 0);
`endif
    tick(1);
    // async reset mid-ownership; the first tie afterwards goes to port 0
    req0 = 1; tick(1);
    chk("t30_gnt0", 32'(gnt0), 1);
    rst_n = 0; #1;
    chk("t30_async_gnt0", 32'(gnt0), 0);
    chk("t30_async_mem_req", 32'(mem_req), 0);
    chk("t30_async_sel", 32'(sel), 0);
    req1 = 1;
    tick(1); rst_n = 1; #1;
    chk("t30_no_early_grant", 32'(mem_req), 0);
    tick(1);
    chk("t30_tie_port0", 32'(gnt0), 1);
    req0 = 0; req1 = 0; done = 1; tick(1); done = 0;
    tick(1);
    // done in IDLE is ignored; req1 toggling during OWN0 is ignored
    done = 1; tick(1); done = 0;
    chk("t31_done_idle", 32'(mem_req), 0);
    req0 = 1; tick(1); req0 = 0;
    chk("t31_gnt0", 32'(gnt0), 1);
    req1 = 1; tick(1); req1 = 0; tick(1);
    chk("t31_own0_kept", 32'(gnt0), 1);
    chk("t31_no_gnt1", 32'(gnt1), 0);
    done = 1; tick(1); done = 0;
    chk("t31_released", 32'(mem_req), 0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
